// File: rtl/note_tone_gen.sv
// Square-wave note player: fetches a half-period from the note ROM and toggles the speaker for a tick-counted duration.
// Optional NOTE_GAP_EN appends GAP_TICKS silent ticks after every note.
module note_tone_gen #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned GAP_TICKS = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             note_valid_i,
  output logic             note_ready_o,
  input  logic [3:0]       note_idx_i,
  input  logic [DUR_W-1:0] note_dur_i,
  output logic [3:0]       rom_addr_o,
  input  logic [31:0]      rom_data_i,
  output logic             speaker_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         rom_addr_q, rom_addr_d;
  logic [DUR_W-1:0]   dur_r_q, dur_r_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic [31:0]        hp_q, hp_d;
  logic [31:0]        phase_q, phase_d;
  logic [31:0]        tick_q, tick_d;
  logic               speaker_q, speaker_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               tick_wrap;
  logic               finish_note;

`ifdef NOTE_GAP_EN
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);
`else
  logic unused_gap;
  assign unused_gap = ^32'(GAP_TICKS);
`endif

  assign tick_wrap = (tick_q == TICK_LAST);

  // Next-state logic; finish_note funnels every path back to IDLE with a done pulse.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    dur_r_d     = dur_r_q;
    dur_cnt_d   = dur_cnt_q;
    hp_d        = hp_q;
    phase_d     = phase_q;
    tick_d      = tick_q;
    speaker_d   = speaker_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    finish_note = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (note_valid_i && ready_q) begin
          rom_addr_d = note_idx_i;
          dur_r_d    = note_dur_i;
          state_d    = S_LOAD;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_LOAD: begin
        hp_d      = rom_data_i;
        phase_d   = '0;
        tick_d    = '0;
        dur_cnt_d = '0;
        speaker_d = 1'b0;
        if (dur_r_q == '0) begin
`ifdef NOTE_GAP_EN
          state_d = S_GAP;
`else
          finish_note = 1'b1;
`endif
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        tick_d = tick_wrap ? '0 : tick_q + 32'd1;
        // A zero half-period is a rest: phase stays parked and speaker stays low.
        if (hp_q != '0) begin
          if (phase_q == hp_q - 32'd1) begin
            phase_d   = '0;
            speaker_d = ~speaker_q;
          end else begin
            phase_d = phase_q + 32'd1;
          end
        end
        if (tick_wrap) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          if (dur_cnt_q == dur_r_q - DUR_W'(1)) begin
            speaker_d = 1'b0;
            phase_d   = '0;
            tick_d    = '0;
            dur_cnt_d = '0;
`ifdef NOTE_GAP_EN
            state_d = S_GAP;
`else
            finish_note = 1'b1;
`endif
          end
        end
      end
`ifdef NOTE_GAP_EN
      S_GAP: begin
        speaker_d = 1'b0;
        tick_d    = tick_wrap ? '0 : tick_q + 32'd1;
        if (tick_wrap) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
          if (dur_cnt_q == GAP_LAST) begin
            dur_cnt_d   = '0;
            finish_note = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (finish_note) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      dur_r_q    <= '0;
      dur_cnt_q  <= '0;
      hp_q       <= '0;
      phase_q    <= '0;
      tick_q     <= '0;
      speaker_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      dur_r_q    <= dur_r_d;
      dur_cnt_q  <= dur_cnt_d;
      hp_q       <= hp_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      speaker_q  <= speaker_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign note_ready_o = ready_q;
  assign rom_addr_o   = rom_addr_q;
  assign speaker_o    = speaker_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: timeline model of each accepted note checked every cycle, plus hand-pinned literals.
module tb_note_tone_gen;
  localparam int unsigned TD = 4;
  localparam int unsigned GT = 2;
  localparam int unsigned DW = 16;
`ifdef NOTE_GAP_EN
  localparam int GAP_CYC = GT * TD;
`else
  localparam int GAP_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          note_valid = 1'b0;
  logic [3:0]    note_idx = '0;
  logic [DW-1:0] note_dur = '0;
  logic          note_ready, speaker, busy, done;
  logic [3:0]    rom_addr;
  logic [31:0]   rom_data;
  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  note_tone_gen #(.TICK_DIV(TD), .DUR_W(DW), .GAP_TICKS(GT)) dut (
    .clk_i(clk), .reset_i(reset), .note_valid_i(note_valid), .note_ready_o(note_ready),
    .note_idx_i(note_idx), .note_dur_i(note_dur), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .speaker_o(speaker), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_fn(input logic [3:0] a);
    case (a)
      4'd0:    return 32'd3;
      4'd1:    return 32'd5;
      4'd12:   return 32'd0;
      default: return 32'(a) + 32'd2;
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model: each accepted note is a timeline of LOAD, play, gap, then a done cycle.
  bit         m_live = 1'b0;
  bit         m_act  = 1'b0;
  int         m_rel, m_end, m_hp, m_play;
  logic [3:0] m_addr = '0;

  always @(negedge clk) begin
    logic e_ready, e_busy, e_done, e_spk;
    if (m_live) begin
      if (!m_act) begin
        e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_spk = 1'b0;
      end else if (m_rel < m_end) begin
        e_ready = 1'b0; e_busy = 1'b1; e_done = 1'b0;
        e_spk = (m_rel >= 2 && m_rel < 2 + m_play && m_hp != 0) ? (((m_rel - 2) / m_hp) % 2 == 1) : 1'b0;
      end else begin
        e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b1; e_spk = 1'b0;
      end
      check("model_ready", note_ready, e_ready);
      check("model_busy", busy, e_busy);
      check("model_done", done, e_done);
      check("model_speaker", speaker, e_spk);
      check("model_rom_addr", rom_addr, m_addr);
    end
    if (reset) begin
      m_live = 1'b1; m_act = 1'b0; m_addr = '0;
    end else if (m_live) begin
      if ((!m_act || m_rel == m_end) && note_valid) begin
        m_act  = 1'b1;
        m_rel  = 1;
        m_addr = note_idx;
        m_hp   = int'(rom_fn(note_idx));
        m_play = int'(note_dur) * int'(TD);
        m_end  = 2 + m_play + GAP_CYC;
      end else if (m_act) begin
        if (m_rel == m_end) m_act = 1'b0;
        else m_rel++;
      end
    end
  end

  // Caller sits just after a posedge; returns just after the posedge following the accept cycle.
  task automatic send(input logic [3:0] idx, input logic [DW-1:0] dur, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    note_valid = 1'b1; note_idx = idx; note_dur = dur;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (note_ready) begin got = 1'b1; acc = cyc; end
    end
    if (!got) begin check("accept_timeout", 32'd0, 32'd1); acc = cyc; end
    @(posedge clk); #1;
    note_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    int n, a1, a2, a3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", note_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_speaker", speaker, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // idx0 (half-period 3) for 3 ticks
    send(4'd0, 16'd3, n);
    wait_cyc(n + 1);  check("t1_addr", rom_addr, 0); check("t1_busy", busy, 1);
    wait_cyc(n + 4);  check("t1_spk_n4", speaker, 0);
    wait_cyc(n + 5);  check("t1_spk_n5", speaker, 1);
    wait_cyc(n + 8);  check("t1_spk_n8", speaker, 0);
    wait_cyc(n + 13); check("t1_spk_n13", speaker, 1); check("t1_done_n13", done, 0);
    wait_cyc(n + 14 + GAP_CYC); check("t1_done", done, 1); check("t1_spk_end", speaker, 0);
    @(posedge clk); #1;

    // rest for 2 ticks
    send(4'd12, 16'd2, n);
    wait_cyc(n + 6);  check("t2_spk", speaker, 0);
    wait_cyc(n + 9);  check("t2_done_early", done, 0);
    wait_cyc(n + 10 + GAP_CYC); check("t2_done", done, 1);
    @(posedge clk); #1;

    // zero duration
    send(4'd1, 16'd0, n);
    wait_cyc(n + 1); check("t3_addr", rom_addr, 1); check("t3_done_early", done, 0);
    wait_cyc(n + 2 + GAP_CYC); check("t3_done", done, 1);
    @(posedge clk); #1;

    // back-to-back with valid held high
    send(4'd1, 16'd1, a1);
    send(4'd0, 16'd2, a2);
    send(4'd12, 16'd1, a3);
    check("t4_b2b_2", a2, a1 + 6 + GAP_CYC);
    check("t4_b2b_3", a3, a2 + 10 + GAP_CYC);
    wait_cyc(a3 + 3); check("t4_ready_busy", note_ready, 0);
    wait_cyc(a3 + 6 + GAP_CYC); check("t4_done", done, 1);
    @(posedge clk); #1;

    // reset mid-PLAY while speaker is high
    send(4'd0, 16'd3, n);
    wait_cyc(n + 4);
    @(posedge clk); #1;
    check("t5_spk_pre", speaker, 1);
    reset = 1'b1;
    wait_cyc(n + 6);
    check("t5_spk", speaker, 0); check("t5_busy", busy, 0); check("t5_ready", note_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_cyc(n + 20); check("t5_no_done", done, 0);
    @(posedge clk); #1;

`ifdef NOTE_GAP_EN
    send(4'd0, 16'd1, n);
    wait_cyc(n + 10); check("t6_gap_spk", speaker, 0); check("t6_gap_busy", busy, 1);
    wait_cyc(n + 13); check("t6_done_early", done, 0);
    wait_cyc(n + 14); check("t6_done", done, 1);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
